seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle shift engine for the 16-bit RISC datapath. It accepts a value, a shift opcode (same 2-bit encoding as the datapath shifter) and a shift amount. It then applies the one-bit operation once per clock until the amount is exhausted, and reports the result with a `start`/`done` handshake. It sits beside the single-cycle shifter and serves multi-bit shift instructions that the combinational path cannot execute in one cycle.

## Interface
- `WIDTH`, 16, data width in bits.
- `CNTW`, 4, width of `amount`; must satisfy 2^CNTW ≥ WIDTH.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when not `busy`.
- `in`  input  WIDTH  operand, latched on an accepted `start`.
- `shift`  input  2  opcode, latched on an accepted `start`:
  - 00: pass.
  - 01: logical left by 1, LSB←0.
  - 10: logical right by 1, MSB←0.
  - 11: arithmetic right by 1, MSB←MSB.
- `amount`  input  CNTW  number of one-bit steps (0..2^CNTW−1), latched on an accepted `start`.
- `busy`  output  1  high while in SHIFT.
- `done`  output  1  one-cycle pulse when `sout` becomes valid.
- `sout`  output  WIDTH  result; holds its value until the next accepted `start`.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, `busy`=0, `done`=0, `sout`=0, internal count=0.
- **IDLE/DONE + `start`=1:** latch `in`, `shift` and `amount`.
  - If `amount`=0 or `shift`=00: load `sout`=`in` and go to DONE.
  - Otherwise: load `sout`=`in`, count=`amount`, and go to SHIFT.
- **IDLE/DONE + `start`=0:** go to IDLE; `sout` is unchanged.
- **SHIFT, each edge:**
  - `sout` ← op(`sout`); count ← count−1.
  - If count was 1, go to DONE; otherwise stay in SHIFT.
- **`start` while in SHIFT:** ignored. Inputs are not re-latched and the operation in progress is unaffected.
- **Outputs by state:**
  - `done`=1 only in DONE.
  - `busy`=1 only in SHIFT.
  - `busy` and `done` are never both high.
- **Width rules:** amounts ≥ WIDTH are legal. Logical shifts give all-zeros. ASR gives all copies of the original MSB.
- **Reset mid-operation:** the operation is abandoned and everything returns to reset values on that edge. The next `start` behaves normally.

## Timing
- `start` accepted at edge k with `amount`=N≥1 and `shift`≠00:
  - `busy` is high for cycles k..k+N−1.
  - `done` is high for the cycle after edge k+N.
  - Latency is N+1 edges to `done`, N edges of shifting.
- N=0 or `shift`=00: `done` is high after edge k; latency is 1 edge.
- `sout` is valid whenever `done`=1 and remains stable until the next accepted `start`.
- Back-to-back: `start` may be asserted during the `done` cycle and is accepted on that edge, giving zero idle cycles between operations.

## Configuration
- **Macro:** `SEQ_SHIFTER_EARLY_EXIT_EN`.
- **Defined:** in SHIFT, the FSM also goes to DONE on any edge where op(`sout`) is a fixed point:
  - all-zeros for `shift` 01/10;
  - all-zeros or all-ones for `shift` 11.
  - The result is identical; only latency shrinks.
  - `done` may therefore arrive earlier than the nominal N+1 edges.
- **Undefined:** always exactly N shift edges. Latency is deterministic at N+1 edges.

## Test plan
- `in`=0xF0CF, `shift`=01, `amount`=4, `start` pulse → `busy` for 4 cycles, then `done` pulse with `sout`=0x0CF0.
- `in`=0xF0CF, `shift`=10, `amount`=4, then `shift`=11, `amount`=4 (issued back-to-back during `done`) → `sout`=0x0F0C, then `sout`=0xFF0C, with no idle cycle between them.
- `in`=0xF0CF, `shift`=01, `amount`=0, and separately `shift`=00, `amount`=7 → `done` one edge after `start`, `sout`=0xF0CF, `busy` never high.
- `in`=0x8000, `shift`=01, `amount`=15:
  - without macro → `done` after 16 edges, `sout`=0x0000;
  - with `SEQ_SHIFTER_EARLY_EXIT_EN` → `done` after 2 edges, `sout`=0x0000.
- `in`=0xF0CF, `shift`=10, `amount`=8; assert `start` with `in`=0x1234 during cycle 3 → ignored; `done` after 9 edges with `sout`=0x00F0.
- Same as previous, but `reset` high in cycle 3 → next edge `busy`=0, `done`=0, `sout`=0x0000. A following `start` with `in`=0x0001, `shift`=01, `amount`=3 → `sout`=0x0008.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift engine that applies a one-bit shift once per
// clock until the requested amount is used up. Results are returned through a
// start/done handshake.
// Optional feature: define SEQ_SHIFTER_EARLY_EXIT_EN to leave SHIFT as soon as
// the next value is a fixed point of the operation.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [CNTW-1:0]  amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   count;
  logic [1:0]        op;
  logic [WIDTH-1:0]  shifted;
  logic              fixed_pt;

  // Apply one step of the latched opcode to the current result.
  always_comb begin
    shifted = sout;
    case (op)
      2'b01:   shifted = {sout[WIDTH-2:0], 1'b0};
      2'b10:   shifted = {1'b0, sout[WIDTH-1:1]};
      2'b11:   shifted = {sout[WIDTH-1], sout[WIDTH-1:1]};
      default: shifted = sout;
    endcase
  end

  // Further steps would not change the next value. All-ones is only stable
  // under ASR.
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
  always_comb begin
    fixed_pt = (shifted == '0) || ((op == 2'b11) && (shifted == '1));
  end
`else
  always_comb begin
    fixed_pt = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. A new start is accepted from either IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (!start)                               state_nxt = IDLE;
        else if ((amount == '0) || (shift == 2'b00)) state_nxt = DONE;
        else                                      state_nxt = SHIFT;
      end
      SHIFT: begin
        if ((count == CNTW'(1)) || fixed_pt) state_nxt = DONE;
        else                                 state_nxt = SHIFT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are latched on an accepted start, and the result
  // register is stepped while in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      sout  <= '0;
      count <= '0;
      op    <= 2'b00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sout  <= in;
            count <= amount;
            op    <= shift;
          end
        end
        SHIFT: begin
          sout  <= shifted;
          count <= count - CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter. Expected results are queued when an
// operation is issued and compared when done is observed.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in = '0;
  logic [1:0]  shift = '0;
  logic [3:0]  amount = '0;
  logic        busy, done;
  logic [15:0] sout;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int k_edge = 0;

  typedef struct { logic [15:0] res; int lat; logic busy_exp; string tag; } exp_t;
  exp_t sb[$];

  seq_shifter #(.WIDTH(16), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in(in), .shift(shift),
    .amount(amount), .busy(busy), .done(done), .sout(sout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive a request that is accepted on the next edge.
  task automatic start_op(input string tag, input logic [15:0] d, input logic [1:0] s,
                          input logic [3:0] a, input logic [15:0] res, input int lat);
    exp_t e;
    e.res = res; e.lat = lat; e.tag = tag;
    e.busy_exp = (a != 0) && (s != 2'b00);
    sb.push_back(e);
    in = d; shift = s; amount = a; start = 1'b1;
    @(posedge clk);
    #1;
    k_edge = edge_cnt;
    start = 1'b0;
    in = 16'hDEAD;
  endtask

  // Wait at negedges for done, then pop the scoreboard and compare the result,
  // latency and busy behaviour. Returns at the negedge inside the done cycle.
  task automatic wait_done();
    exp_t e;
    bit   busy_ok = 1'b1;
    bit   seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (busy !== e.busy_exp) busy_ok = 1'b0;
    end
    chk({e.tag, "_timeout"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({e.tag, "_sout"}, {16'd0, sout}, {16'd0, e.res});
      chk({e.tag, "_latency"}, edge_cnt - k_edge + 1, e.lat);
      chk({e.tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      chk({e.tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sout", {16'd0, sout}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Left shift by 4
    start_op("lsl4", 16'hF0CF, 2'b01, 4'd4, 16'h0CF0, 5);
    wait_done();
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);
    chk("sout_hold", {16'd0, sout}, 32'h0CF0);

    // LSR then ASR issued back-to-back from the done cycle
    start_op("lsr4", 16'hF0CF, 2'b10, 4'd4, 16'h0F0C, 5);
    wait_done();
    start_op("asr4", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, 5);
    wait_done();

    // Zero amount and pass opcode both finish in one edge
    @(negedge clk);
    start_op("amt0", 16'hF0CF, 2'b01, 4'd0, 16'hF0CF, 1);
    wait_done();
    @(negedge clk);
    start_op("pass", 16'hF0CF, 2'b00, 4'd7, 16'hF0CF, 1);
    wait_done();

    // Shift the MSB completely out
    @(negedge clk);
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
    start_op("lsl15", 16'h8000, 2'b01, 4'd15, 16'h0000, 2);
`else
    start_op("lsl15", 16'h8000, 2'b01, 4'd15, 16'h0000, 16);
`endif
    wait_done();

    // A start while busy is ignored
    @(negedge clk);
    start_op("ign", 16'hF0CF, 2'b10, 4'd8, 16'h00F0, 9);
    @(negedge clk);
    @(negedge clk);
    in = 16'h1234; shift = 2'b01; amount = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of an operation abandons it
    @(negedge clk);
    start_op("rstmid", 16'hF0CF, 2'b10, 4'd8, 16'h00F0, 9);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 0);
    chk("rstmid_done", {31'd0, done}, 0);
    chk("rstmid_sout", {16'd0, sout}, 0);
    @(negedge clk);
    start_op("after_rst", 16'h0001, 2'b01, 4'd3, 16'h0008, 4);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
